// File: rtl/wb_pkg.sv
// Shared types and default sizes for the writeback port arbiter.
// wb_entry_t is one queued long-latency result.
package wb_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int MAX_WAIT   = 8;

  typedef struct packed {
    logic              fp;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Circular FIFO of wb_entry_t holding long-latency results.
// Ports: clk, rst (async low), push/din, pop, head, full, empty.
module wb_arb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  // Extra MSB on each pointer tells full from empty.
  logic [AW:0] wp;
  logic [AW:0] rp;
  wb_entry_t   mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + ONE;
      if (pop)  rp <= rp + ONE;
    end
  end

  // Storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares int/FP register-file write ports between writeback and one LL return path.
// Ports: pipe_* in, ll_* handshake, rf_*/frf_* writes, stall_o, ll_done_* pulse.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = wb_pkg::DATA_W,
  parameter int ADDR_W     = wb_pkg::ADDR_W,
  parameter int FIFO_DEPTH = wb_pkg::FIFO_DEPTH,
  parameter int MAX_WAIT   = wb_pkg::MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we_i,
  input  logic              pipe_fwe_i,
  input  logic [ADDR_W-1:0] pipe_rd_i,
  input  logic [DATA_W-1:0] pipe_data_i,
  input  logic              ll_valid_i,
  output logic              ll_ready_o,
  input  logic              ll_fp_i,
  input  logic [ADDR_W-1:0] ll_rd_i,
  input  logic [DATA_W-1:0] ll_data_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_rd_o,
  output logic [DATA_W-1:0] rf_wd_o,
  output logic              frf_we_o,
  output logic [ADDR_W-1:0] frf_rd_o,
  output logic [DATA_W-1:0] frf_wd_o,
  output logic              stall_o,
  output logic              ll_done_o,
  output logic              ll_done_fp_o,
  output logic [ADDR_W-1:0] ll_done_rd_o
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WONE = WW'(1);

  wb_entry_t din;
  wb_entry_t head;
  logic      full;
  logic      empty;
  logic      push;
  logic      pop;
  logic      hv;
  logic      drop;
  logic      conflict;
  logic      hwr;
  logic      h_int;
  logic      h_fp;
  logic [WW-1:0] wait_cnt;

  assign din.fp   = ll_fp_i;
  assign din.rd   = ll_rd_i;
  assign din.data = ll_data_i;

  // Room is judged from registered state only.
  assign ll_ready_o = !full;
  assign push       = ll_valid_i && !full;

  wb_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign hv       = !empty;
  assign stall_o  = hv && (wait_cnt == WMAX);
  // Integer x0 results carry nothing worth writing.
  assign drop     = hv && !head.fp && (head.rd == '0);
  assign conflict = head.fp ? pipe_fwe_i : pipe_we_i;
  assign hwr      = hv && !drop && (stall_o || !conflict);
  assign pop      = hwr || drop;
  assign h_int    = hwr && !head.fp;
  assign h_fp     = hwr && head.fp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!hv || pop) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WMAX) begin
      wait_cnt <= wait_cnt + WONE;
    end
  end

  // Without a stall the head only takes a port the pipe left idle,
  // so at most one source drives each port.
  always_comb begin
    rf_we_o  = 1'b0;
    rf_rd_o  = '0;
    rf_wd_o  = '0;
    frf_we_o = 1'b0;
    frf_rd_o = '0;
    frf_wd_o = '0;
    unique case (1'b1)
      h_int: begin
        rf_we_o = 1'b1;
        rf_rd_o = head.rd;
        rf_wd_o = head.data;
      end
      (pipe_we_i && !stall_o): begin
        rf_we_o = 1'b1;
        rf_rd_o = pipe_rd_i;
        rf_wd_o = pipe_data_i;
      end
      default: ;
    endcase
    unique case (1'b1)
      h_fp: begin
        frf_we_o = 1'b1;
        frf_rd_o = head.rd;
        frf_wd_o = head.data;
      end
      (pipe_fwe_i && !stall_o): begin
        frf_we_o = 1'b1;
        frf_rd_o = pipe_rd_i;
        frf_wd_o = pipe_data_i;
      end
      default: ;
    endcase
  end

  assign ll_done_o    = pop;
  assign ll_done_fp_o = pop && head.fp;
  assign ll_done_rd_o = pop ? head.rd : '0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter.
// Drives after posedge, checks on negedge.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we_i;
  logic        pipe_fwe_i;
  logic [4:0]  pipe_rd_i;
  logic [31:0] pipe_data_i;
  logic        ll_valid_i;
  logic        ll_ready_o;
  logic        ll_fp_i;
  logic [4:0]  ll_rd_i;
  logic [31:0] ll_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wd_o;
  logic        frf_we_o;
  logic [4:0]  frf_rd_o;
  logic [31:0] frf_wd_o;
  logic        stall_o;
  logic        ll_done_o;
  logic        ll_done_fp_o;
  logic [4:0]  ll_done_rd_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_we_i    (pipe_we_i),
    .pipe_fwe_i   (pipe_fwe_i),
    .pipe_rd_i    (pipe_rd_i),
    .pipe_data_i  (pipe_data_i),
    .ll_valid_i   (ll_valid_i),
    .ll_ready_o   (ll_ready_o),
    .ll_fp_i      (ll_fp_i),
    .ll_rd_i      (ll_rd_i),
    .ll_data_i    (ll_data_i),
    .rf_we_o      (rf_we_o),
    .rf_rd_o      (rf_rd_o),
    .rf_wd_o      (rf_wd_o),
    .frf_we_o     (frf_we_o),
    .frf_rd_o     (frf_rd_o),
    .frf_wd_o     (frf_wd_o),
    .stall_o      (stall_o),
    .ll_done_o    (ll_done_o),
    .ll_done_fp_o (ll_done_fp_o),
    .ll_done_rd_o (ll_done_rd_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic ll(input logic v, input logic fp,
                    input logic [4:0] rd, input logic [31:0] d);
    ll_valid_i = v;
    ll_fp_i    = fp;
    ll_rd_i    = rd;
    ll_data_i  = d;
  endtask

  task automatic pw(input logic we, input logic fwe,
                    input logic [4:0] rd, input logic [31:0] d);
    pipe_we_i   = we;
    pipe_fwe_i  = fwe;
    pipe_rd_i   = rd;
    pipe_data_i = d;
  endtask

  task automatic quiet(input string tag);
    chk({tag, "_rfwe"}, 32'(rf_we_o), 32'd0);
    chk({tag, "_frfwe"}, 32'(frf_we_o), 32'd0);
    chk({tag, "_done"}, 32'(ll_done_o), 32'd0);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    pw(0, 0, 0, 0);
    ll(0, 0, 0, 0);
    #12;
    quiet("rst");
    chk("rst_ready", 32'(ll_ready_o), 32'd1);
    chk("rst_rfrd", 32'(rf_rd_o), 32'd0);
    chk("rst_donerd", 32'(ll_done_rd_o), 32'd0);
    smp();
    rst = 1'b1;

    // T1: single int LL write on idle pipe
    nxt();
    ll(1, 0, 5, 32'h1234);
    smp();
    chk("t1_ready", 32'(ll_ready_o), 32'd1);
    chk("t1_nobypass", 32'(rf_we_o), 32'd0);
    nxt();
    ll(0, 0, 0, 0);
    smp();
    chk("t1_we", 32'(rf_we_o), 32'd1);
    chk("t1_rd", 32'(rf_rd_o), 32'd5);
    chk("t1_wd", rf_wd_o, 32'h1234);
    chk("t1_done", 32'(ll_done_o), 32'd1);
    chk("t1_done_rd", 32'(ll_done_rd_o), 32'd5);
    chk("t1_done_fp", 32'(ll_done_fp_o), 32'd0);
    nxt();
    smp();
    quiet("t1_after");

    // T2: starvation stall
    nxt();
    pw(1, 0, 1, 32'hAAAA);
    ll(1, 0, 7, 32'h7777);
    smp();
    chk("t2_push_wd", rf_wd_o, 32'hAAAA);
    nxt();
    ll(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      smp();
      chk("t2_blk_stall", 32'(stall_o), 32'd0);
      chk("t2_blk_wd", rf_wd_o, 32'hAAAA);
      chk("t2_blk_done", 32'(ll_done_o), 32'd0);
      nxt();
    end
    smp();
    chk("t2_stall", 32'(stall_o), 32'd1);
    chk("t2_st_we", 32'(rf_we_o), 32'd1);
    chk("t2_st_rd", 32'(rf_rd_o), 32'd7);
    chk("t2_st_wd", rf_wd_o, 32'h7777);
    chk("t2_st_done", 32'(ll_done_o), 32'd1);
    nxt();
    smp();
    chk("t2_resume_stall", 32'(stall_o), 32'd0);
    chk("t2_resume_wd", rf_wd_o, 32'hAAAA);
    chk("t2_resume_rd", 32'(rf_rd_o), 32'd1);
    nxt();
    pw(0, 0, 0, 0);

    // T3: FP head alongside int pipe write
    ll(1, 1, 3, 32'hF00D);
    nxt();
    ll(0, 0, 0, 0);
    pw(1, 0, 3, 32'h3333);
    smp();
    chk("t3_rfwe", 32'(rf_we_o), 32'd1);
    chk("t3_rfwd", rf_wd_o, 32'h3333);
    chk("t3_frfwe", 32'(frf_we_o), 32'd1);
    chk("t3_frfrd", 32'(frf_rd_o), 32'd3);
    chk("t3_frfwd", frf_wd_o, 32'hF00D);
    chk("t3_stall", 32'(stall_o), 32'd0);
    chk("t3_done_fp", 32'(ll_done_fp_o), 32'd1);
    nxt();
    pw(0, 0, 0, 0);
    smp();
    quiet("t3_after");

    // T4: backpressure and ordering
    nxt();
    pw(1, 0, 2, 32'h2222);
    ll(1, 0, 10, 32'hA1);
    smp();
    chk("t4_rdy1", 32'(ll_ready_o), 32'd1);
    nxt();
    ll(1, 0, 11, 32'hA2);
    smp();
    chk("t4_rdy2", 32'(ll_ready_o), 32'd1);
    nxt();
    ll(1, 0, 12, 32'hA3);
    smp();
    chk("t4_full", 32'(ll_ready_o), 32'd0);
    chk("t4_blk_wd", rf_wd_o, 32'h2222);
    nxt();
    pw(0, 0, 0, 0);
    smp();
    chk("t4_w1_rd", 32'(rf_rd_o), 32'd10);
    chk("t4_w1_wd", rf_wd_o, 32'hA1);
    chk("t4_w1_rdy", 32'(ll_ready_o), 32'd0);
    nxt();
    smp();
    chk("t4_w2_rd", 32'(rf_rd_o), 32'd11);
    chk("t4_w2_wd", rf_wd_o, 32'hA2);
    chk("t4_w2_rdy", 32'(ll_ready_o), 32'd1);
    nxt();
    ll(0, 0, 0, 0);
    smp();
    chk("t4_w3_rd", 32'(rf_rd_o), 32'd12);
    chk("t4_w3_wd", rf_wd_o, 32'hA3);
    chk("t4_w3_done", 32'(ll_done_o), 32'd1);
    nxt();
    smp();
    quiet("t4_after");

    // T5: integer x0 result is dropped
    nxt();
    ll(1, 0, 0, 32'hDEAD);
    nxt();
    ll(0, 0, 0, 0);
    smp();
    chk("t5_rfwe", 32'(rf_we_o), 32'd0);
    chk("t5_done", 32'(ll_done_o), 32'd1);
    chk("t5_done_rd", 32'(ll_done_rd_o), 32'd0);
    chk("t5_done_fp", 32'(ll_done_fp_o), 32'd0);
    nxt();
    smp();
    quiet("t5_after");

    // T6: reset discards queued entries
    nxt();
    pw(1, 0, 4, 32'h4444);
    ll(1, 0, 20, 32'hB0);
    nxt();
    ll(1, 0, 21, 32'hB1);
    nxt();
    ll(0, 0, 0, 0);
    #2;
    rst = 1'b0;
    pw(0, 0, 0, 0);
    #1;
    quiet("t6_inrst");
    chk("t6_ready", 32'(ll_ready_o), 32'd1);
    nxt();
    smp();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt();
      smp();
      quiet("t6_post");
      chk("t6_post_rdy", 32'(ll_ready_o), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
